// File: rtl/debug_unit.sv
// Byte-command debug controller: loads instruction memory, runs/steps the core
// and dumps PC plus register file over a byte link.
module debug_unit #(
   parameter int NB_INST = 32,
   parameter int NB_ADDR = 32,
   parameter int NB_REG  = 5,
   parameter int NB_BYTE = 8,
   parameter int N_REGS  = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx_valid,
   input  logic [NB_BYTE-1:0] i_rx_data,
   output logic               o_tx_valid,
   output logic [NB_BYTE-1:0] o_tx_data,
   input  logic               i_tx_ready,
   output logic               o_enable,
   output logic               o_imem_write,
   output logic [NB_ADDR-1:0] o_imem_addr,
   output logic [NB_INST-1:0] o_imem_data,
   output logic [NB_REG-1:0]  o_reg_addr,
   input  logic [NB_INST-1:0] i_reg_data,
   input  logic [NB_ADDR-1:0] i_pc,
   input  logic               i_halt
);

   localparam int NB_BCNT = $clog2(NB_INST / NB_BYTE);
   localparam int NB_CNT  = NB_BYTE + 1;
   localparam int NB_RIDX = $clog2(N_REGS + 1);

   localparam logic [NB_BYTE-1:0] CMD_L = 'h4C;
   localparam logic [NB_BYTE-1:0] CMD_C = 'h43;
   localparam logic [NB_BYTE-1:0] CMD_S = 'h53;
   localparam logic [NB_BYTE-1:0] CMD_R = 'h52;
   localparam logic [NB_BYTE-1:0] CMD_B = 'h42;
   localparam logic [NB_BYTE-1:0] RSP_K = 'h4B;
   localparam logic [NB_BYTE-1:0] RSP_H = 'h48;
   localparam logic [NB_BYTE-1:0] RSP_Q = 'h3F;

   typedef enum logic [3:0] {
      ST_IDLE, ST_LOAD_CNT, ST_LOAD_DATA, ST_RUN, ST_STEP,
      ST_DUMP_LATCH, ST_DUMP_CAP, ST_DUMP_SEND, ST_DUMP_WAIT, ST_TX
   } state_t;

   state_t               r_state,    w_state;
   logic                 r_enable,   w_enable;
   logic                 r_write,    w_write;
   logic [NB_ADDR-1:0]   r_addr,     w_addr;
   logic [NB_INST-1:0]   r_data,     w_data;
   logic [NB_REG-1:0]    r_reg_addr, w_reg_addr;
   logic                 r_tx_valid, w_tx_valid;
   logic [NB_BYTE-1:0]   r_tx_data,  w_tx_data;
   logic [NB_CNT-1:0]    r_count,    w_count;
   logic [NB_CNT-1:0]    r_word,     w_word;
   logic [NB_BCNT-1:0]   r_bcnt,     w_bcnt;
   logic [NB_RIDX-1:0]   r_ridx,     w_ridx;
   logic [NB_INST-1:0]   r_shift,    w_shift;
   logic [NB_CNT-1:0]    w_word_inc;

   assign w_word_inc = r_word + NB_CNT'(1);

   always_comb begin
      w_state    = r_state;
      w_enable   = r_enable;
      w_write    = 1'b0;
      w_addr     = r_addr;
      w_data     = r_data;
      w_reg_addr = r_reg_addr;
      w_tx_valid = r_tx_valid;
      w_tx_data  = r_tx_data;
      w_count    = r_count;
      w_word     = r_word;
      w_bcnt     = r_bcnt;
      w_ridx     = r_ridx;
      w_shift    = r_shift;
      case (r_state)
         ST_IDLE: if (i_rx_valid) begin
            case (i_rx_data)
               CMD_L: w_state = ST_LOAD_CNT;
               CMD_C: begin
                  w_state  = ST_RUN;
                  w_enable = 1'b1;
               end
               CMD_S: if (i_halt) begin
                  w_tx_valid = 1'b1;
                  w_tx_data  = RSP_H;
                  w_state    = ST_TX;
               end else begin
                  w_state  = ST_STEP;
                  w_enable = 1'b1;
               end
               CMD_R: begin
                  w_shift = NB_INST'(i_pc);
                  w_bcnt  = '0;
                  w_ridx  = '0;
                  w_state = ST_DUMP_SEND;
               end
               default: begin
                  w_tx_valid = 1'b1;
                  w_tx_data  = RSP_Q;
                  w_state    = ST_TX;
               end
            endcase
         end
         ST_LOAD_CNT: if (i_rx_valid) begin
            w_count = (i_rx_data == '0) ? NB_CNT'(1 << NB_BYTE) : NB_CNT'(i_rx_data);
            w_word  = '0;
            w_bcnt  = '0;
            w_state = ST_LOAD_DATA;
         end
         ST_LOAD_DATA: if (i_rx_valid) begin
            w_data = {r_data[NB_INST-NB_BYTE-1:0], i_rx_data};
            w_bcnt = r_bcnt + NB_BCNT'(1);
            if (r_bcnt == '1) begin
               w_write = 1'b1;
               w_addr  = NB_ADDR'(r_word[NB_BYTE-1:0]);
               w_word  = w_word_inc;
               if (w_word_inc == r_count) begin
                  w_tx_valid = 1'b1;
                  w_tx_data  = RSP_K;
                  w_state    = ST_TX;
               end
            end
         end
         // halt and 'B' in the same cycle collapse into one stop
         ST_RUN: if (i_halt || (i_rx_valid && i_rx_data == CMD_B)) begin
            w_enable   = 1'b0;
            w_tx_valid = 1'b1;
            w_tx_data  = RSP_H;
            w_state    = ST_TX;
         end
         ST_STEP: begin
            w_enable   = 1'b0;
            w_tx_valid = 1'b1;
            w_tx_data  = RSP_K;
            w_state    = ST_TX;
         end
         ST_DUMP_SEND: begin
            w_tx_valid = 1'b1;
            w_tx_data  = r_shift[NB_INST-1 -: NB_BYTE];
            w_shift    = r_shift << NB_BYTE;
            w_state    = ST_DUMP_WAIT;
         end
         // r_ridx counts words already sent: 0 is the PC, r is register r-1
         ST_DUMP_WAIT: if (i_tx_ready) begin
            w_tx_valid = 1'b0;
            w_bcnt     = r_bcnt + NB_BCNT'(1);
            if (r_bcnt != '1) begin
               w_state = ST_DUMP_SEND;
            end else if (r_ridx == NB_RIDX'(N_REGS)) begin
               w_reg_addr = '0;
               w_tx_valid = 1'b1;
               w_tx_data  = RSP_K;
               w_state    = ST_TX;
            end else begin
               w_reg_addr = NB_REG'(r_ridx);
               w_ridx     = r_ridx + NB_RIDX'(1);
               w_state    = ST_DUMP_LATCH;
            end
         end
         ST_DUMP_LATCH: w_state = ST_DUMP_CAP;
         ST_DUMP_CAP: begin
            w_shift = i_reg_data;
            w_state = ST_DUMP_SEND;
         end
         ST_TX: if (i_tx_ready) begin
            w_tx_valid = 1'b0;
            w_state    = ST_IDLE;
         end
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state    <= ST_IDLE;
         r_enable   <= 1'b0;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_reg_addr <= '0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
         r_count    <= '0;
         r_word     <= '0;
         r_bcnt     <= '0;
         r_ridx     <= '0;
         r_shift    <= '0;
      end else begin
         r_state    <= w_state;
         r_enable   <= w_enable;
         r_write    <= w_write;
         r_addr     <= w_addr;
         r_data     <= w_data;
         r_reg_addr <= w_reg_addr;
         r_tx_valid <= w_tx_valid;
         r_tx_data  <= w_tx_data;
         r_count    <= w_count;
         r_word     <= w_word;
         r_bcnt     <= w_bcnt;
         r_ridx     <= w_ridx;
         r_shift    <= w_shift;
      end
   end

   assign o_enable     = r_enable;
   assign o_imem_write = r_write;
   assign o_imem_addr  = r_addr;
   assign o_imem_data  = r_data;
   assign o_reg_addr   = r_reg_addr;
   assign o_tx_valid   = r_tx_valid;
   assign o_tx_data    = r_tx_data;

endmodule
